// File: rtl/ram_arbiter_if.sv
// One requester port of the RAM arbiter: req/ack handshake with address, write data and read-back.
interface ram_arbiter_if;
    logic       req;
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic       ack;
    logic [7:0] rdata;
    logic       err;

    modport master (output req, we, addr, wdata, input  ack, rdata, err);
    modport slave  (input  req, we, addr, wdata, output ack, rdata, err);
endinterface

// File: rtl/ram_arbiter.sv
// Shares one single-port RAM between ports A and B; req sampled in IDLE -> 1-cycle ACCESS -> 1-cycle ack (3-cycle turnaround).
// Backpressure: a losing requester holds req and is served next; out-of-range accesses are blocked and ack with err.
module ram_arbiter #(
    parameter logic [7:0] RAM_MIN    = 8'h00,
    parameter logic [7:0] RAM_MAX    = 8'h79,
    parameter bit         FIXED_PRIO = 1'b0
) (
    input  logic          clock,
    input  logic          reset_s2_n,
    ram_arbiter_if.slave  port_a,
    ram_arbiter_if.slave  port_b,
    output logic [7:0]    ram_address,
    output logic [7:0]    ram_data_in,
    output logic          ram_write_enable,
    input  logic [7:0]    ram_data_out
);

    typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;

    state_t     state;
    logic       last_b;
    logic       grant_b;
    logic       we_q;
    logic       ok_q;

    logic       pick_b;
    logic [7:0] nxt_addr;
    logic [7:0] nxt_wdata;
    logic       nxt_we;
    logic       nxt_ok;

    // Signed 9-bit compares keep the range check free of constant-compare quirks when RAM_MIN is 0.
    always_comb begin
        pick_b    = port_b.req && (!port_a.req || (!FIXED_PRIO && !last_b));
        nxt_addr  = pick_b ? port_b.addr  : port_a.addr;
        nxt_wdata = pick_b ? port_b.wdata : port_a.wdata;
        nxt_we    = pick_b ? port_b.we    : port_a.we;
        nxt_ok    = ($signed({1'b0, nxt_addr}) >= $signed({1'b0, RAM_MIN})) &&
                    ($signed({1'b0, nxt_addr}) <= $signed({1'b0, RAM_MAX}));
    end

    always_ff @(posedge clock or negedge reset_s2_n) begin
        if (!reset_s2_n) begin
            state            <= IDLE;
            last_b           <= 1'b1;
            grant_b          <= 1'b0;
            we_q             <= 1'b0;
            ok_q             <= 1'b0;
            ram_address      <= 8'h00;
            ram_data_in      <= 8'h00;
            ram_write_enable <= 1'b0;
            port_a.ack       <= 1'b0;
            port_a.err       <= 1'b0;
            port_a.rdata     <= 8'h00;
            port_b.ack       <= 1'b0;
            port_b.err       <= 1'b0;
            port_b.rdata     <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (port_a.req || port_b.req) begin
                        state            <= ACCESS;
                        grant_b          <= pick_b;
                        last_b           <= pick_b;
                        we_q             <= nxt_we;
                        ok_q             <= nxt_ok;
                        ram_address      <= nxt_addr;
                        ram_data_in      <= nxt_wdata;
                        ram_write_enable <= nxt_we && nxt_ok;
                    end
                end
                ACCESS: begin
                    state            <= ACK;
                    ram_address      <= 8'h00;
                    ram_data_in      <= 8'h00;
                    ram_write_enable <= 1'b0;
                    // Writes leave the port's last read data untouched.
                    if (grant_b) begin
                        port_b.ack <= 1'b1;
                        port_b.err <= !ok_q;
                        if (!we_q)
                            port_b.rdata <= ok_q ? ram_data_out : 8'h00;
                    end else begin
                        port_a.ack <= 1'b1;
                        port_a.err <= !ok_q;
                        if (!we_q)
                            port_a.rdata <= ok_q ? ram_data_out : 8'h00;
                    end
                end
                ACK: begin
                    state      <= IDLE;
                    port_a.ack <= 1'b0;
                    port_a.err <= 1'b0;
                    port_b.ack <= 1'b0;
                    port_b.err <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed and random checks of ram_arbiter in round-robin and fixed-priority builds against a reference memory.
module tb_ram_arbiter;

    localparam logic [7:0] RAM_MAX = 8'h79;

    logic clock = 1'b0;
    logic reset_s2_n;
    always #10 clock = ~clock;

    ram_arbiter_if rr_a ();
    ram_arbiter_if rr_b ();
    ram_arbiter_if fp_a ();
    ram_arbiter_if fp_b ();

    logic [7:0] rr_addr, rr_din, rr_dout;
    logic [7:0] fp_addr, fp_din, fp_dout;
    logic       rr_we, fp_we;

    logic [7:0] rr_ram  [256];
    logic [7:0] fp_ram  [256];
    logic [7:0] ref_mem [256];

    int n_checks = 0;
    int n_errors = 0;
    int we_cnt   = 0;
    int cyc      = 0;
    bit mon_on   = 1'b0;

    ram_arbiter #(.FIXED_PRIO(1'b0)) dut_rr (
        .clock(clock), .reset_s2_n(reset_s2_n), .port_a(rr_a), .port_b(rr_b),
        .ram_address(rr_addr), .ram_data_in(rr_din), .ram_write_enable(rr_we), .ram_data_out(rr_dout)
    );

    ram_arbiter #(.FIXED_PRIO(1'b1)) dut_fp (
        .clock(clock), .reset_s2_n(reset_s2_n), .port_a(fp_a), .port_b(fp_b),
        .ram_address(fp_addr), .ram_data_in(fp_din), .ram_write_enable(fp_we), .ram_data_out(fp_dout)
    );

    assign rr_dout = rr_ram[rr_addr];
    assign fp_dout = fp_ram[fp_addr];

    always @(posedge clock) begin
        cyc++;
        if (rr_we) begin
            rr_ram[rr_addr] <= rr_din;
            we_cnt++;
        end
        if (fp_we)
            fp_ram[fp_addr] <= fp_din;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Acks must be one-hot and a write may only appear in ACCESS, in range.
    always @(negedge clock) begin
        if (mon_on) begin
            check("rr_ack_onehot", 32'(rr_a.ack & rr_b.ack), 0);
            check("fp_ack_onehot", 32'(fp_a.ack & fp_b.ack), 0);
            check("rr_we_ctx", 32'(rr_we & ((rr_addr > RAM_MAX) | rr_a.ack | rr_b.ack)), 0);
            check("fp_we_ctx", 32'(fp_we & ((fp_addr > RAM_MAX) | fp_a.ack | fp_b.ack)), 0);
        end
    end

    task automatic acc(input bit pb, input bit we, input logic [7:0] addr, input logic [7:0] wdata,
                       input string tag, output int lat);
        logic       ack_s, err_s;
        logic [7:0] rd_s, exp_rd;
        bit         ok;
        ok     = (addr <= RAM_MAX);
        ack_s  = 1'b0;
        err_s  = 1'b0;
        rd_s   = 8'h00;
        lat    = 0;
        if (pb) begin
            rr_b.req = 1'b1; rr_b.we = we; rr_b.addr = addr; rr_b.wdata = wdata;
        end else begin
            rr_a.req = 1'b1; rr_a.we = we; rr_a.addr = addr; rr_a.wdata = wdata;
        end
        while (!ack_s && lat < 30) begin
            @(negedge clock);
            lat++;
            ack_s = pb ? rr_b.ack   : rr_a.ack;
            err_s = pb ? rr_b.err   : rr_a.err;
            rd_s  = pb ? rr_b.rdata : rr_a.rdata;
        end
        if (pb) rr_b.req = 1'b0;
        else    rr_a.req = 1'b0;
        check({tag, "_ack"}, 32'(ack_s), 1);
        if (ack_s) begin
            check({tag, "_err"}, 32'(err_s), 32'(!ok));
            if (!we) begin
                exp_rd = ok ? ref_mem[addr] : 8'h00;
                check({tag, "_rdata"}, 32'(rd_s), 32'(exp_rd));
            end else if (ok) begin
                ref_mem[addr] = wdata;
            end
        end
        @(negedge clock);
    endtask

    task automatic tie(input string tag, input bit exp_first);
        int n   = 0;
        int cnt = 0;
        bit order [2];
        order[0] = 1'b0;
        order[1] = 1'b0;
        rr_a.req = 1'b1; rr_a.we = 1'b0; rr_a.addr = 8'h10;
        rr_b.req = 1'b1; rr_b.we = 1'b0; rr_b.addr = 8'h11;
        while (n < 2 && cnt < 40) begin
            @(negedge clock);
            cnt++;
            if (rr_a.ack) begin
                if (n < 2) order[n] = 1'b0;
                n++;
                rr_a.req = 1'b0;
            end
            if (rr_b.ack) begin
                if (n < 2) order[n] = 1'b1;
                n++;
                rr_b.req = 1'b0;
            end
        end
        rr_a.req = 1'b0;
        rr_b.req = 1'b0;
        check({tag, "_count"}, n, 2);
        check({tag, "_first"}, 32'(order[0]), 32'(exp_first));
        check({tag, "_second"}, 32'(order[1]), 32'(!exp_first));
        @(negedge clock);
    endtask

    function automatic logic [7:0] rand_addr();
        if ($urandom_range(0, 9) == 0)
            return 8'h78 + 8'($urandom_range(0, 3));
        return 8'($urandom_range(0, 15));
    endfunction

    initial begin
        int lat, we0, na, nb_at, cnt, cyc_end, lat_a, lat_b;
        for (int i = 0; i < 256; i++) begin
            rr_ram[i]  = 8'h00;
            fp_ram[i]  = 8'h00;
            ref_mem[i] = 8'h00;
        end
        rr_a.req = 0; rr_a.we = 0; rr_a.addr = 0; rr_a.wdata = 0;
        rr_b.req = 0; rr_b.we = 0; rr_b.addr = 0; rr_b.wdata = 0;
        fp_a.req = 0; fp_a.we = 0; fp_a.addr = 0; fp_a.wdata = 0;
        fp_b.req = 0; fp_b.we = 0; fp_b.addr = 0; fp_b.wdata = 0;
        reset_s2_n = 1'b0;

        // Reset state
        repeat (3) @(negedge clock);
        check("rst_outs", 32'({rr_a.ack, rr_a.err, rr_b.ack, rr_b.err, rr_we, fp_we}), 0);
        check("rst_rdata", 32'({rr_a.rdata, rr_b.rdata}), 0);
        check("rst_ram_bus", 32'({rr_addr, rr_din}), 0);
        reset_s2_n = 1'b1;
        mon_on     = 1'b1;
        @(negedge clock);

        // A write then read back
        we0 = we_cnt;
        acc(1'b0, 1'b1, 8'h10, 8'h5A, "a_wr10", lat);
        check("a_wr10_lat", lat, 2);
        check("a_wr10_we_cycles", we_cnt - we0, 1);
        check("a_wr10_ram", 32'(rr_ram[8'h10]), 32'h5A);
        we0 = we_cnt;
        acc(1'b0, 1'b0, 8'h10, 8'h00, "a_rd10", lat);
        check("a_rd10_lat", lat, 2);
        check("a_rd10_we_cycles", we_cnt - we0, 0);

        // B: out-of-range blocked, boundary address accepted
        acc(1'b1, 1'b0, 8'h10, 8'h00, "b_rd10", lat);
        we0 = we_cnt;
        acc(1'b1, 1'b1, 8'h7A, 8'hFF, "b_wr7a", lat);
        check("b_wr7a_we_cycles", we_cnt - we0, 0);
        check("b_wr7a_ram", 32'(rr_ram[8'h7A]), 0);
        acc(1'b1, 1'b0, 8'h7A, 8'h00, "b_rd7a", lat);
        we0 = we_cnt;
        acc(1'b1, 1'b1, 8'h79, 8'h33, "b_wr79", lat);
        check("b_wr79_we_cycles", we_cnt - we0, 1);
        check("b_wr79_ram", 32'(rr_ram[8'h79]), 32'h33);
        acc(1'b1, 1'b0, 8'h79, 8'h00, "b_rd79", lat);
        acc(1'b1, 1'b0, 8'hFF, 8'h00, "b_rdff", lat);

        // Round-robin ties alternate
        tie("tie1", 1'b0);
        tie("tie2", 1'b0);
        acc(1'b0, 1'b0, 8'h10, 8'h00, "a_rd10b", lat);
        tie("tie3", 1'b1);
        tie("tie4", 1'b1);

        // Reset during an ACCESS write
        rr_a.req = 1'b1; rr_a.we = 1'b1; rr_a.addr = 8'h20; rr_a.wdata = 8'h77;
        @(negedge clock);
        check("rstmid_pre_we", 32'(rr_we), 1);
        reset_s2_n = 1'b0;
        #1;
        check("rstmid_we", 32'(rr_we), 0);
        check("rstmid_bus", 32'({rr_addr, rr_din}), 0);
        check("rstmid_rdata", 32'(rr_a.rdata), 0);
        rr_a.req = 1'b0;
        @(negedge clock);
        check("rstmid_ram", 32'(rr_ram[8'h20]), 0);
        reset_s2_n = 1'b1;
        repeat (3) begin
            @(negedge clock);
            check("rstmid_no_ack", 32'(rr_a.ack | rr_b.ack), 0);
        end
        acc(1'b0, 1'b0, 8'h20, 8'h00, "rstmid_rd20", lat);
        check("rstmid_rd20_lat", lat, 2);

        // Fixed priority: B only served once A stops requesting
        fp_a.req = 1'b1; fp_a.we = 1'b0; fp_a.addr = 8'h01;
        fp_b.req = 1'b1; fp_b.we = 1'b0; fp_b.addr = 8'h02;
        na = 0; nb_at = -1; cnt = 0;
        while (nb_at < 0 && cnt < 60) begin
            @(negedge clock);
            cnt++;
            if (fp_a.ack) begin
                na++;
                if (na == 3) fp_a.req = 1'b0;
            end
            if (fp_b.ack) begin
                nb_at    = na;
                fp_b.req = 1'b0;
            end
        end
        fp_a.req = 1'b0;
        fp_b.req = 1'b0;
        check("fp_b_after_a", nb_at, 3);
        @(negedge clock);

        // Random interleaved traffic against the reference memory
        cyc_end = cyc + 10000;
        fork
            begin
                while (cyc < cyc_end) begin
                    repeat ($urandom_range(0, 3)) @(negedge clock);
                    acc(1'b0, 1'($urandom_range(0, 1)), rand_addr(), 8'($urandom), "rnd_a", lat_a);
                end
            end
            begin
                while (cyc < cyc_end) begin
                    repeat ($urandom_range(0, 3)) @(negedge clock);
                    acc(1'b1, 1'($urandom_range(0, 1)), rand_addr(), 8'($urandom), "rnd_b", lat_b);
                end
            end
        join

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
